// File: rtl/rt_mem_pkg.sv
// Shared types and constants for the racetrack/LiM port-B readback engine.
package rt_mem_pkg;

  localparam int unsigned RT_WORD_BYTES  = 4;
  localparam logic [3:0]  BE_ALL         = 4'hF;
  localparam logic [31:0] LIM_FUNCT_NONE = '0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_RV = 3'd2,
    ST_OUT     = 3'd3,
    ST_GAP     = 3'd4
  } rb_state_e;

endpackage

// File: rtl/rt_readback_timer.sv
// Loadable down-counter for the per-word rvalid timeout; the expiry flag is
// high when the count has reached zero.
module rt_readback_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;

  // Load with TIMEOUT_CYCLES-1 so zero is reached on the last allowed wait cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/rt_mem_readback.sv
// Port-B memory readback engine: walks a word-aligned range, issues one plain
// read per word, waits for rvalid and streams each word out on valid/ready.
// Optional build macro RT_READBACK_CHECKSUM_EN adds checksum_o.
module rt_mem_readback
  import rt_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 22,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FUNCT_WIDTH    = 3,
  parameter int unsigned RANGE_WIDTH    = 5,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [ADDR_WIDTH-3:0]  num_words_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_timeout_o,
  output logic                   en_b_o,
  output logic                   we_b_o,
  output logic [3:0]             be_b_o,
  output logic [DATA_WIDTH-1:0]  wdata_b_o,
  output logic [ADDR_WIDTH-1:0]  addr_b_o,
  output logic [FUNCT_WIDTH-1:0] logic_in_memory_funct_o,
  output logic                   we_b_funct_mem_o,
  output logic [RANGE_WIDTH-1:0] addr_b_range_o,
  input  logic [DATA_WIDTH-1:0]  rdata_b_i,
  input  logic                   rvalid_b_i,
  output logic [DATA_WIDTH-1:0]  dout_o,
  output logic [ADDR_WIDTH-1:0]  dout_addr_o,
  output logic                   dout_valid_o,
`ifdef RT_READBACK_CHECKSUM_EN
  output logic [31:0]            checksum_o,
`endif
  input  logic                   dout_ready_i
);

  localparam int unsigned RW = ADDR_WIDTH - 2;

  rb_state_e             r_state, w_state_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [RW-1:0]         r_remaining, w_remaining_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;
  logic                  r_err, w_err_d;
  logic                  r_en_b;
  logic [DATA_WIDTH-1:0] r_dout, w_dout_d;
  logic [ADDR_WIDTH-1:0] r_dout_addr, w_dout_addr_d;
  logic                  r_dout_valid;
  logic                  w_timer_load, w_timer_dec, w_expired;
  logic                  w_start_acc, w_accept;

  rt_readback_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_timer_load),
    .i_dec      (w_timer_dec),
    .o_expired_c(w_expired)
  );

  // Next-state and next-register values; rvalid takes priority over timeout.
  always_comb begin
    w_state_d     = r_state;
    w_addr_d      = r_addr;
    w_remaining_d = r_remaining;
    w_busy_d      = r_busy;
    w_done_d      = 1'b0;
    w_err_d       = r_err;
    w_dout_d      = r_dout;
    w_dout_addr_d = r_dout_addr;
    w_timer_load  = 1'b0;
    w_timer_dec   = 1'b0;
    w_start_acc   = 1'b0;
    w_accept      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i && !r_busy) begin
          w_start_acc   = 1'b1;
          w_err_d       = 1'b0;
          w_busy_d      = 1'b1;
          w_addr_d      = base_addr_i & ~ADDR_WIDTH'(RT_WORD_BYTES - 1);
          w_remaining_d = num_words_i;
          if (num_words_i == '0) begin
            w_done_d = 1'b1;
          end else begin
            w_state_d = ST_REQ;
          end
        end else begin
          // Empty-range starts stay busy for exactly one cycle.
          w_busy_d = 1'b0;
        end
      end
      ST_REQ: begin
        w_timer_load = 1'b1;
        w_state_d    = ST_WAIT_RV;
      end
      ST_WAIT_RV: begin
        w_timer_dec = 1'b1;
        if (rvalid_b_i) begin
          w_dout_d      = rdata_b_i;
          w_dout_addr_d = r_addr;
          w_state_d     = ST_OUT;
        end else if (w_expired) begin
          w_err_d   = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (dout_ready_i) begin
          w_accept  = 1'b1;
          w_state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        w_remaining_d = r_remaining - RW'(1);
        if (r_remaining == RW'(1)) begin
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = ST_IDLE;
        end else begin
          w_addr_d  = r_addr + ADDR_WIDTH'(RT_WORD_BYTES);
          w_state_d = ST_REQ;
        end
      end
      default: begin
        w_busy_d  = 1'b0;
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; strobes are derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_en_b       <= 1'b0;
      r_dout       <= '0;
      r_dout_addr  <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_addr       <= w_addr_d;
      r_remaining  <= w_remaining_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
      r_en_b       <= (w_state_d == ST_REQ);
      r_dout       <= w_dout_d;
      r_dout_addr  <= w_dout_addr_d;
      r_dout_valid <= (w_state_d == ST_OUT);
    end
  end

`ifdef RT_READBACK_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running sum of words accepted on the stream since the last start.
  always_ff @(posedge clk_i) begin
    if (rst_i || w_start_acc) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + 32'(r_dout);
    end
  end

  assign checksum_o = r_checksum;
`endif

  assign busy_o                  = r_busy;
  assign done_o                  = r_done;
  assign err_timeout_o           = r_err;
  assign en_b_o                  = r_en_b;
  assign addr_b_o                = r_addr;
  assign dout_o                  = r_dout;
  assign dout_addr_o             = r_dout_addr;
  assign dout_valid_o            = r_dout_valid;
  assign we_b_o                  = 1'b0;
  assign be_b_o                  = BE_ALL;
  assign wdata_b_o               = '0;
  assign logic_in_memory_funct_o = FUNCT_WIDTH'(LIM_FUNCT_NONE);
  assign we_b_funct_mem_o        = 1'b0;
  assign addr_b_range_o          = '0;

endmodule
